// File: rtl/mips_alu_driver_if.sv
// Instruction handshake and completion bundle between the instruction source
// (master) and mips_alu_driver (slave).
interface mips_alu_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic        done;
  logic [31:0] done_result;
  logic [2:0]  done_flag;
  logic        branch_taken;
  logic        illegal;
  logic        ovf_trap;

  modport master (
    output in_valid, in_ins,
    input  in_ready, done, done_result, done_flag, branch_taken, illegal, ovf_trap
  );

  modport slave (
    input  in_valid, in_ins,
    output in_ready, done, done_result, done_flag, branch_taken, illegal, ovf_trap
  );
endinterface

// File: rtl/mips_alu_driver.sv
// mips_alu_driver: issue/writeback sequencer in front of a combinational mips_alu.
// Accepts one instruction, reads operands from a local register file, drives the
// ALU for one cycle, captures result/flag, writes back and pulses done.
// Optional feature macro: MIPS_DRV_OVF_TRAP_EN -- overflowing add/sub/addi skip
// writeback and raise ovf_trap together with done.
module mips_alu_driver #(
  parameter int          REG_NUM   = 32,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  mips_alu_driver_if.slave io,
  output logic [31:0]      alu_ins,
  output logic [31:0]      alu_regA,
  output logic [31:0]      alu_regB,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flag,
  input  logic             init_we,
  input  logic [4:0]       init_addr,
  input  logic [31:0]      init_data,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data
);
  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] rf [REG_NUM];

  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, imm_ext, opb;
  logic        r_type, r_ok, i_alu, mem_op, br_op, idx_bad, dec_ill, accept;

  // decode results carried from accept to the end of ISSUE
  logic        pend_wb, pend_br, pend_ill;
  logic [4:0]  pend_idx;
  logic        trap_hit;

  // completion outputs, held until the next completion
  logic [31:0] res_q;
  logic [2:0]  flag_q;
  logic        br_q, ill_q, trap_q;

  function automatic logic bad_idx(input logic [4:0] idx);
    return int'(idx) >= REG_NUM;
  endfunction

  assign opc    = io.in_ins[31:26];
  assign rs     = io.in_ins[25:21];
  assign rt     = io.in_ins[20:16];
  assign rd     = io.in_ins[15:11];
  assign funct  = io.in_ins[5:0];

  assign r_type = (opc == 6'h00);
  assign r_ok   = r_type && (funct inside {[6'h20:6'h27], 6'h2A, 6'h2B});
  assign i_alu  = opc inside {[6'h08:6'h0E]};
  assign mem_op = opc inside {6'h23, 6'h2B};
  assign br_op  = opc inside {6'h04, 6'h05};

  // every field the instruction names must address a real register
  assign idx_bad = bad_idx(rs) || bad_idx(rt) || (r_type && bad_idx(rd));
  assign dec_ill = !(r_ok || i_alu || mem_op || br_op) || idx_bad;

  // register 0 and out-of-range indices read as zero
  assign rs_val = (rs == 5'd0 || bad_idx(rs)) ? 32'd0 : rf[rs[AW-1:0]];
  assign rt_val = (rt == 5'd0 || bad_idx(rt)) ? 32'd0 : rf[rt[AW-1:0]];
  assign dbg_data = (dbg_addr == 5'd0 || bad_idx(dbg_addr)) ? 32'd0 : rf[dbg_addr[AW-1:0]];

  // logical immediates zero-extend, everything else sign-extends
  assign imm_ext = (opc inside {[6'h0C:6'h0E]}) ? {16'd0, io.in_ins[15:0]}
                                                : {{16{io.in_ins[15]}}, io.in_ins[15:0]};
  assign opb     = (r_type || br_op) ? rt_val : imm_ext;

  assign accept  = io.in_valid && io.in_ready;

`ifdef MIPS_DRV_OVF_TRAP_EN
  logic pend_trap;
  // remember whether the accepted op is one that traps on overflow
  always_ff @(posedge clk) begin
    if (rst)         pend_trap <= 1'b0;
    else if (accept) pend_trap <= (r_type && (funct == 6'h20 || funct == 6'h22)) || (opc == 6'h08);
  end
  assign trap_hit = pend_trap && !pend_ill && alu_flag[0];
`else
  assign trap_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, handshake and done pulse
  always_comb begin
    state_nxt   = state;
    io.in_ready = 1'b0;
    io.done     = 1'b0;
    case (state)
      IDLE: begin
        io.in_ready = !init_we;
        if (io.in_valid && !init_we) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = DONE;
      DONE: begin
        io.done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive at accept, result capture at the end of ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ins  <= '0;
      alu_regA <= '0;
      alu_regB <= '0;
      pend_wb  <= 1'b0;
      pend_br  <= 1'b0;
      pend_ill <= 1'b0;
      pend_idx <= '0;
      res_q    <= '0;
      flag_q   <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      if (accept) begin
        // fixed rs=0/rt=1 fields make the ALU take regA/regB as its operands
        alu_ins  <= {opc, 5'd0, 5'd1, io.in_ins[15:0]};
        alu_regA <= rs_val;
        alu_regB <= opb;
        pend_wb  <= !dec_ill && (r_type || i_alu);
        pend_br  <= !dec_ill && br_op;
        pend_ill <= dec_ill;
        pend_idx <= r_type ? rd : rt;
      end
      if (state == ISSUE) begin
        res_q  <= pend_ill ? 32'd0 : alu_result;
        flag_q <= pend_ill ? 3'd0  : alu_flag;
        br_q   <= pend_br && alu_flag[2];
        ill_q  <= pend_ill;
        trap_q <= trap_hit;
      end
    end
  end

  // register file: preload while idle, writeback at the end of ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= RESET_VAL;
    end else if (state == IDLE && init_we && init_addr != 5'd0 && !bad_idx(init_addr)) begin
      rf[init_addr[AW-1:0]] <= init_data;
    end else if (state == ISSUE && pend_wb && !trap_hit && pend_idx != 5'd0) begin
      rf[pend_idx[AW-1:0]] <= alu_result;
    end
  end

  assign io.done_result  = res_q;
  assign io.done_flag    = flag_q;
  assign io.branch_taken = br_q   && io.done;
  assign io.illegal      = ill_q  && io.done;
  assign io.ovf_trap     = trap_q && io.done;
endmodule

// File: tb/tb_mips_alu_driver.sv
// Bench for mips_alu_driver: a behavioural mips_alu stands in for the real ALU,
// and a register-file model predicts every completion and writeback.
module tb_mips_alu_driver;
  localparam logic [31:0] RV = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_ins, alu_regA, alu_regB, alu_result;
  logic [2:0]  alu_flag;
  logic        init_we;
  logic [4:0]  init_addr, dbg_addr;
  logic [31:0] init_data, dbg_data;

  mips_alu_driver_if bus();

  mips_alu_driver #(.REG_NUM(32), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .io(bus),
    .alu_ins(alu_ins), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins, a, b, res;
    logic [2:0]  flag;
    logic        d_issue, d_done, d_after, br, ill, trap, tail, hold;
  } rsp_t;

  int          total = 0, bad = 0;
  rsp_t        o, e;
  logic [31:0] m_rf [32];
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;

  // ALU behaviour: returns {zero,neg,ovf,result}
  function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] op;
    logic [31:0] r;
    logic z, n, v;
    op = ins[31:26]; r = 32'd0; n = 1'b0; v = 1'b0;
    if (op == 6'h00) begin
      case (ins[5:0])
        6'h20: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); n = $signed(a) < $signed(b); end
        6'h23: begin r = a - b; n = a < b; end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = {31'd0, $signed(a) < $signed(b)};
        6'h2B: r = {31'd0, a < b};
        default: r = 32'd0;
      endcase
    end else begin
      case (op)
        6'h08: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h09, 6'h23, 6'h2B: r = a + b;
        6'h0A: r = {31'd0, $signed(a) < $signed(b)};
        6'h0B: r = {31'd0, a < b};
        6'h0C: r = a & b;
        6'h0D: r = a | b;
        6'h0E: r = a ^ b;
        6'h04, 6'h05: r = a - b;
        default: r = 32'd0;
      endcase
    end
    z = (r == 32'd0);
    if (op == 6'h04) z = (a == b);
    if (op == 6'h05) z = (a != b);
    return {z, n, v, r};
  endfunction

  always_comb {alu_flag, alu_result} = alu_fn(alu_ins, alu_regA, alu_regB);

  function automatic logic legal(input logic [31:0] ins);
    logic [5:0] op, f;
    op = ins[31:26]; f = ins[5:0];
    if (op == 6'h00) return (f >= 6'h20 && f <= 6'h27) || f == 6'h2A || f == 6'h2B;
    return (op >= 6'h08 && op <= 6'h0E) || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05;
  endfunction

  function automatic logic [31:0] mrd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : m_rf[idx];
  endfunction

  // expected completion plus pending model writeback for one instruction
  task automatic predict(input logic [31:0] ins);
    logic [5:0] op;
    logic [31:0] a, b;
    logic [34:0] fr;
    op = ins[31:26];
    a = mrd(ins[25:21]);
    if (op == 6'h00 || op == 6'h04 || op == 6'h05) b = mrd(ins[20:16]);
    else if (op >= 6'h0C && op <= 6'h0E)           b = {16'd0, ins[15:0]};
    else                                            b = {{16{ins[15]}}, ins[15:0]};
    fr = alu_fn(ins, a, b);
    e = '0;
    e.ins = {op, 5'd0, 5'd1, ins[15:0]}; e.a = a; e.b = b; e.d_done = 1'b1; e.hold = 1'b1;
    wb_en = 1'b0; wb_idx = (op == 6'h00) ? ins[15:11] : ins[20:16]; wb_val = fr[31:0];
    if (!legal(ins)) e.ill = 1'b1;
    else begin
      e.res = fr[31:0]; e.flag = fr[34:32];
      e.br = (op == 6'h04 || op == 6'h05) && fr[34];
`ifdef MIPS_DRV_OVF_TRAP_EN
      e.trap = ((op == 6'h00 && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22)) || op == 6'h08) && fr[32];
`endif
      wb_en = (op == 6'h00 || (op >= 6'h08 && op <= 6'h0E)) && !e.trap;
    end
  endtask

  task automatic commit();
    if (wb_en && wb_idx != 5'd0) m_rf[wb_idx] = wb_val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; init_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = RV;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] v);
    @(negedge clk);
    init_we = 1'b1; init_addr = idx; init_data = v;
    @(posedge clk);
    #1 init_we = 1'b0;
    if (idx != 5'd0) m_rf[idx] = v;
  endtask

  task automatic peek(input logic [4:0] idx, output logic [31:0] v);
    dbg_addr = idx;
    #1 v = dbg_data;
  endtask

  // issue one instruction and record what the driver shows in each phase
  task automatic run_ins(input logic [31:0] ins);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) begin total++; bad++; $display("FAIL accept_timeout ins=%h in_ready=%b need=1", ins, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_ins = ins;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.in_ins = $urandom;
    @(negedge clk);
    o = '0;
    o.d_issue = bus.done; o.ins = alu_ins; o.a = alu_regA; o.b = alu_regB;
    @(negedge clk);
    o.d_done = bus.done; o.res = bus.done_result; o.flag = bus.done_flag;
    o.br = bus.branch_taken; o.ill = bus.illegal; o.trap = bus.ovf_trap;
    @(negedge clk);
    o.d_after = bus.done; o.tail = bus.branch_taken | bus.illegal | bus.ovf_trap;
    o.hold = (bus.done_result === o.res);
  endtask

  function automatic logic [31:0] gen_ins();
    logic [59:0] ftab;
    logic [43:0] otab;
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    int k;
    ftab = {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    otab = {4'h0, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin k = $urandom_range(0, 9); return {6'h00, s, t, d, 5'($urandom), ftab[k*6 +: 6]}; end
      4, 5, 6:    begin k = $urandom_range(0, 6); return {otab[k*6 +: 6], s, t, imm}; end
      7:          return {($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B, s, t, imm};
      8:          return {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, s, t, imm};
      default:    return ($urandom_range(0, 1) != 0) ? {6'h3F, s, t, imm} : {6'h00, s, t, d, 5'd0, 6'h08};
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
    total++; if ({bus.done, bus.branch_taken, bus.illegal, bus.ovf_trap, bus.done_flag} !== 7'd0) begin
      bad++; $display("FAIL rst_status got=%b exp=0", {bus.done, bus.branch_taken, bus.illegal, bus.ovf_trap, bus.done_flag}); end
    total++; if ({bus.done_result, alu_ins, alu_regA, alu_regB} !== 128'd0) begin
      bad++; $display("FAIL rst_regs got=%h/%h/%h/%h exp=0", bus.done_result, alu_ins, alu_regA, alu_regB); end
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      total++; if (v !== ((i == 0) ? 32'd0 : RV)) begin bad++; $display("FAIL rst_rf%0d got=%h exp=%h", i, v, (i == 0) ? 32'd0 : RV); end
    end
    init_we = 1'b1; init_addr = 5'd0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL init_blocks_ready got=%b exp=0", bus.in_ready); end
    init_we = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] v;
    preload(5'd1, 32'd5); preload(5'd2, 32'd7);
    predict(32'h00221820); run_ins(32'h00221820); commit();
    total++; if (o.res !== 32'd12 || o.flag !== 3'b000) begin bad++; $display("FAIL add_res got=%h/%b exp=0000000c/000", o.res, o.flag); end
    total++; if (o !== e) begin bad++; $display("FAIL add_all got=%h exp=%h", o, e); end
    peek(5'd3, v);
    total++; if (v !== 32'd12) begin bad++; $display("FAIL add_wb got=%h exp=0000000c", v); end
    predict(32'h2004FFFF); run_ins(32'h2004FFFF); commit();
    total++; if (o.res !== 32'hFFFFFFFF || o.flag !== 3'b000) begin bad++; $display("FAIL addi_res got=%h/%b exp=ffffffff/000", o.res, o.flag); end
    peek(5'd4, v);
    total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_wb got=%h exp=ffffffff", v); end
    preload(5'd5, 32'h7FFFFFFF); preload(5'd6, 32'd1);
    predict(32'h00A63820); run_ins(32'h00A63820); commit();
    total++; if (o.res !== 32'h80000000 || o.flag !== 3'b001) begin bad++; $display("FAIL ovf_res got=%h/%b exp=80000000/001", o.res, o.flag); end
    peek(5'd7, v);
`ifdef MIPS_DRV_OVF_TRAP_EN
    total++; if (o.trap !== 1'b1 || v !== RV) begin bad++; $display("FAIL ovf_trap got=%b/%h exp=1/%h", o.trap, v, RV); end
`else
    total++; if (o.trap !== 1'b0 || v !== 32'h80000000) begin bad++; $display("FAIL ovf_wrap got=%b/%h exp=0/80000000", o.trap, v); end
`endif
  endtask

  task automatic test_branch();
    logic [31:0] v;
    logic [31:0] br_ins [4];
    logic [3:0]  br_exp;
    br_ins = '{32'h10210004, 32'h14220000, 32'h14210000, 32'h10220000};
    br_exp = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      predict(br_ins[k]); run_ins(br_ins[k]); commit();
      total++; if (o.br !== br_exp[k]) begin bad++; $display("FAIL branch%0d got=%b exp=%b", k, o.br, br_exp[k]); end
      total++; if (o !== e) begin bad++; $display("FAIL branch%0d_all got=%h exp=%h", k, o, e); end
    end
    for (int i = 1; i < 8; i++) begin
      peek(5'(i), v);
      total++; if (v !== m_rf[i]) begin bad++; $display("FAIL branch_rf%0d got=%h exp=%h", i, v, m_rf[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    predict(32'hFC000000); run_ins(32'hFC000000); commit();
    total++; if (o.ill !== 1'b1 || o.res !== 32'd0 || o.flag !== 3'd0) begin bad++; $display("FAIL ill_op got=%b/%h/%b exp=1/0/0", o.ill, o.res, o.flag); end
    predict(32'h0022183F); run_ins(32'h0022183F); commit();
    total++; if (o !== e) begin bad++; $display("FAIL ill_funct got=%h exp=%h", o, e); end
    peek(5'd3, v);
    total++; if (v !== 32'd12) begin bad++; $display("FAIL ill_nowb got=%h exp=0000000c", v); end
    predict(32'h20000005); run_ins(32'h20000005); commit();
    peek(5'd0, v);
    total++; if (v !== 32'd0 || o.res !== 32'd5) begin bad++; $display("FAIL r0_write got=%h/%h exp=0/5", v, o.res); end
  endtask

  task automatic test_random();
    logic [31:0] ins, v, pv;
    logic [4:0]  pi;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        pi = 5'($urandom_range(1, 7));
        case ($urandom_range(0, 3))
          0: pv = 32'h7FFFFFFF;
          1: pv = 32'h80000000;
          2: pv = 32'hFFFFFFFF;
          default: pv = $urandom;
        endcase
        preload(pi, pv);
      end
      ins = gen_ins();
      predict(ins); run_ins(ins); commit();
      total++; if (o !== e) begin bad++; $display("FAIL rand%0d ins=%h got=%h exp=%h", k, ins, o, e); end
    end
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      total++; if (v !== mrd(5'(i))) begin bad++; $display("FAIL rand_rf%0d got=%h exp=%h", i, v, mrd(5'(i))); end
    end
  endtask

  task automatic test_back_to_back();
    int last, n_acc, n_done, gaps;
    logic [31:0] v;
    last = -1; n_acc = 0; n_done = 0; gaps = 0;
    preload(5'd8, 32'h10);
    bus.in_ins = 32'h21080001;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 14) bus.in_valid = 1'b0;
      else if (bus.in_ready) begin
        if (last >= 0 && c - last != 3) gaps++;
        last = c; n_acc++;
      end
      if (bus.done) n_done++;
    end
    repeat (3) begin @(negedge clk); if (bus.done) n_done++; end
    m_rf[8] = 32'h15;
    total++; if (n_acc !== 5 || gaps !== 0) begin bad++; $display("FAIL b2b_accepts got=%0d/%0d exp=5/0", n_acc, gaps); end
    total++; if (n_done !== 5) begin bad++; $display("FAIL b2b_dones got=%0d exp=5", n_done); end
    peek(5'd8, v);
    total++; if (v !== 32'h15) begin bad++; $display("FAIL b2b_wb got=%h exp=00000015", v); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] v;
    logic seen;
    do_reset();
    preload(5'd1, 32'd5); preload(5'd2, 32'd7);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ins = 32'h00221820;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = RV;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL inflight_ready got=%b exp=1", bus.in_ready); end
    seen = bus.done;
    repeat (4) begin @(negedge clk); seen |= bus.done; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL inflight_done got=%b exp=0", seen); end
    total++; if (alu_ins !== 32'd0 || bus.done_result !== 32'd0) begin bad++; $display("FAIL inflight_regs got=%h/%h exp=0/0", alu_ins, bus.done_result); end
    peek(5'd3, v);
    total++; if (v !== RV) begin bad++; $display("FAIL inflight_rf3 got=%h exp=%h", v, RV); end
    peek(5'd1, v);
    total++; if (v !== RV) begin bad++; $display("FAIL inflight_rf1 got=%h exp=%h", v, RV); end
  endtask

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_ins = 32'd0;
    init_we = 1'b0; init_addr = 5'd0; init_data = 32'd0; dbg_addr = 5'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = RV;
    test_reset();
    test_arith();
    test_branch();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
